draw_sprite: RTL
================

Name: draw_sprite

Overview:
- Pipelined pixel stage directly downstream of the VGA timing controller.
- Consumes the timing/background stream on a vga_if and overlays a fixed-size sprite read from an external synchronous pixel ROM.
- Sprite position is latched once per frame.
- Emits the same stream, delayed by 2 cycles, on an output vga_if for the next drawing stage.

Parameters:
- SPR_W, 48, sprite width in pixels.
- SPR_H, 64, sprite height in pixels.
- ADDR_W, 12, ROM address width; must satisfy 2**ADDR_W >= SPR_W*SPR_H.
- TRANSPARENT, 12'hF0F, ROM colour treated as transparent (background shown).

Ports:
- clk  input  1  pixel clock.
- rst  input  1  synchronous, active-high reset.
- vga_in  input  vga_if.in  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0] from the timing/background stage.
- vga_out  output  vga_if.out  same fields, 2-cycle delayed, sprite overlaid.
- xpos  input  11  requested sprite left edge (pixels).
- ypos  input  11  requested sprite top edge (lines).
- en  input  1  sprite enable request.
- rom_addr  output  ADDR_W  registered ROM address.
- rom_data  input  12  ROM pixel, valid 1 cycle after rom_addr (synchronous ROM).

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high (rst).
- Reset values: all vga_out fields 0, rom_addr 0, internal pipeline registers 0, latched position (x_l, y_l) = 0, en_l = 0.
- Frame latch:
  - Rising edge of vga_in.vblnk is detected against a registered copy of vblnk.
  - On that edge: x_l<=xpos, y_l<=ypos, en_l<=en.
  - x_l, y_l and en_l are constant for the whole visible region of the following frame.
  - xpos/ypos/en changes at other times have no effect until the next edge.
- Stage 1 (cycle t+1):
  - Registers hcount, vcount, hsync, vsync, hblnk, vblnk and rgb.
  - in_box = en_l && !hblnk && !vblnk && hcount>=x_l && hcount<x_l+SPR_W && vcount>=y_l && vcount<y_l+SPR_H.
  - Comparisons use 12-bit sums so x_l+SPR_W and y_l+SPR_H never wrap.
  - rom_addr <= (vcount-y_l)*SPR_W + (hcount-x_l), truncated to ADDR_W, when in_box; otherwise rom_addr holds its previous value.
  - in_box is registered alongside.
- Stage 2 (cycle t+2):
  - All timing fields are copied from stage 1.
  - vga_out.rgb = rom_data when stage-1 in_box=1 and rom_data!=TRANSPARENT; otherwise the stage-1 rgb.
- Latency: every vga_out field equals the corresponding vga_in field from 2 cycles earlier, except rgb inside the sprite. hcount/vcount are passed unchanged, never recomputed.
- Clipping:
  - A sprite crossing the right or bottom edge is drawn only where hcount/vcount are in the visible area (blank gating).
  - xpos beyond the active width draws nothing.
  - No wrap to the left or top.
- Blanking: no sprite pixel is ever output while hblnk or vblnk is set; rgb passes through.
- Simultaneous events: a vblnk rising edge on the same cycle as a pixel in_box evaluation uses the old x_l/y_l for that pixel. Unreachable in practice, since vblnk gates in_box.
- Reset mid-frame:
  - Outputs are 0 on the cycle after rst is sampled high.
  - After release, en_l=0, so no sprite is drawn until the next vblnk rising edge; the pass-through stream resumes 2 cycles after release.

Test Plan:
- Pass-through: en=0, full frame of timing stream -> vga_out identical to vga_in delayed 2 cycles, every field, every cycle; rom_addr never changes.
- Basic draw: en=1, xpos=100, ypos=50, ROM returns addr-dependent colour -> rom_addr=0 one cycle after vga_in (100,50), vga_out.rgb=ROM[0] at vga_out (100,50); at vga_in (147,113) rom_addr=3071; (148,50) and (100,114) show background.
- Transparency: ROM word 5 = 12'hF0F, background rgb=12'h123 -> vga_out (105,50) rgb=12'h123; neighbours show ROM colours.
- Latch timing: change xpos 100->200 mid-visible-frame -> current frame still drawn at x=100; next frame at x=200 after vblnk rising edge.
- Edge clipping: xpos=780, ypos=580 on 800x600 timing -> sprite pixels only for hcount 780..799, vcount 580..599; no sprite pixel during blanking; nothing drawn at x<48 or y<64.
- Reset mid-frame: assert rst for 3 cycles at vcount=300 with sprite active -> all vga_out fields 0 the cycle after first rst sample; no sprite pixels until the next vblnk rising edge, then the sprite returns at the latched position.

Source files
------------

// File: rtl/draw_sprite.sv
// Sprite overlay stage: takes the VGA timing/background stream and overlays a
// fixed-size sprite from a synchronous pixel ROM, emitting the stream 2 cycles later.
module draw_sprite #(
  parameter int          SPR_W       = 48,
  parameter int          SPR_H       = 64,
  parameter int          ADDR_W      = 12,
  parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [10:0]       vga_in_hcount,
  input  logic [10:0]       vga_in_vcount,
  input  logic              vga_in_hsync,
  input  logic              vga_in_vsync,
  input  logic              vga_in_hblnk,
  input  logic              vga_in_vblnk,
  input  logic [11:0]       vga_in_rgb,

  output logic [10:0]       vga_out_hcount,
  output logic [10:0]       vga_out_vcount,
  output logic              vga_out_hsync,
  output logic              vga_out_vsync,
  output logic              vga_out_hblnk,
  output logic              vga_out_vblnk,
  output logic [11:0]       vga_out_rgb,

  input  logic [10:0]       xpos,
  input  logic [10:0]       ypos,
  input  logic              en,

  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  vga_t        in_stream;
  vga_t        s1;
  vga_t        s2;
  logic        s1_in_box;
  logic        s2_in_box;

  logic        vblnk_d;
  logic        frame_start;
  logic [10:0] x_l;
  logic [10:0] y_l;
  logic        en_l;

  logic [11:0] x_end;
  logic [11:0] y_end;
  logic [10:0] dx;
  logic [10:0] dy;
  logic        in_box;
  logic [ADDR_W-1:0] addr_next;

  assign in_stream = '{hcount: vga_in_hcount, vcount: vga_in_vcount,
                       hsync:  vga_in_hsync,  vsync:  vga_in_vsync,
                       hblnk:  vga_in_hblnk,  vblnk:  vga_in_vblnk,
                       rgb:    vga_in_rgb};

  // Position/enable are sampled only at the start of vertical blanking so a
  // sprite never tears across a frame.
  assign frame_start = vga_in_vblnk && !vblnk_d;

  // 12-bit right/bottom edges so a sprite near coordinate 2047 cannot wrap.
  assign x_end = {1'b0, x_l} + 12'(SPR_W);
  assign y_end = {1'b0, y_l} + 12'(SPR_H);
  assign dx    = vga_in_hcount - x_l;
  assign dy    = vga_in_vcount - y_l;

  assign in_box = en_l && !vga_in_hblnk && !vga_in_vblnk &&
                  (vga_in_hcount >= x_l) && ({1'b0, vga_in_hcount} < x_end) &&
                  (vga_in_vcount >= y_l) && ({1'b0, vga_in_vcount} < y_end);

  assign addr_next = ADDR_W'(32'(dy) * 32'(SPR_W) + 32'(dx));

  // NOTE: non-blocking assignments make every register here read pre-edge
  // values, so a pixel evaluated on the vblnk edge still uses the old x_l/y_l.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d <= 1'b0;
      x_l     <= '0;
      y_l     <= '0;
      en_l    <= 1'b0;
    end else begin
      vblnk_d <= vga_in_vblnk;
      if (frame_start) begin
        x_l  <= xpos;
        y_l  <= ypos;
        en_l <= en;
      end
    end
  end

  // Stage 1 issues the ROM read; stage 2 lines the stream up with rom_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s1_in_box <= 1'b0;
      rom_addr  <= '0;
      s2        <= '0;
      s2_in_box <= 1'b0;
    end else begin
      s1        <= in_stream;
      s1_in_box <= in_box;
      if (in_box) begin
        rom_addr <= addr_next;
      end
      s2        <= s1;
      s2_in_box <= s1_in_box;
    end
  end

  assign vga_out_hcount = s2.hcount;
  assign vga_out_vcount = s2.vcount;
  assign vga_out_hsync  = s2.hsync;
  assign vga_out_vsync  = s2.vsync;
  assign vga_out_hblnk  = s2.hblnk;
  assign vga_out_vblnk  = s2.vblnk;

  // rom_data only becomes valid in the output cycle, so the colour select
  // sits after the stage-2 registers.
  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    vga_out_rgb = s2.rgb;
    if (s2_in_box && (rom_data != TRANSPARENT)) begin
      vga_out_rgb = rom_data;
    end
  end

endmodule
